// File: rtl/ram_responder_pkg.sv
// Shared types for the RAM responder: FSM state encoding, operation kind
// and the word geometry.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ram_responder_if.sv
// Request/response bundle between the CPU request unit (master) and the
// RAM responder (slave).
//
// Handshake: ren/wen are level requests held by the master until ready;
// ready is a one-cycle completion pulse qualified by err, and the master
// must drop ren/wen in the ready cycle to avoid a repeat transaction.
interface ram_responder_if #(
    parameter int ADDR_W = 32
);
    import mem_pkg::*;

    logic                  ren;
    logic                  wen;
    logic [ADDR_W-1:0]     ramaddr;
    logic [31:0]           ramstore;
    logic [WORD_BYTES-1:0] byte_en;
    logic [31:0]           ramload;
    logic                  busy;
    logic                  ready;
    logic                  err;

    modport master (
        output ren, wen, ramaddr, ramstore, byte_en,
        input  ramload, busy, ready, err
    );

    modport slave (
        input  ren, wen, ramaddr, ramstore, byte_en,
        output ramload, busy, ready, err
    );

endinterface

// File: rtl/ram_responder_word_ram.sv
// Word-organised storage: DEPTH x 32 bits, asynchronous read and
// byte-enabled synchronous write. Contents are never cleared.
module word_ram
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [31:0]           wdata,
    input  logic [WORD_BYTES-1:0] be,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ram_responder.sv
// RAM responder: accepts one request at a time, waits LATENCY cycles, then
// pulses ready. Optional macro MISALIGN_CHECK_EN rejects unaligned addresses.
module ram_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    ram_responder_if.slave  bus,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_W-3:0]     idx_q, idx_d;
    logic [31:0]           data_q, data_d;
    logic [WORD_BYTES-1:0] be_q, be_d;
    mem_op_t               op_q, op_d;
    logic [31:0]           ramload_q, ramload_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;

    logic [ADDR_W-3:0]     cur_idx;
    mem_op_t               cur_op;
    logic                  cur_mis;
    logic                  cur_ok;
    logic                  to_resp;
    logic                  we;
    logic [31:0]           rd_data;

    // In IDLE the live request is examined so LATENCY==1 can respond from it
    // directly; afterwards only the captured copy matters.
    assign cur_idx = (state_q == ST_IDLE) ? bus.ramaddr[ADDR_W-1:2] : idx_q;
    assign cur_op  = (state_q == ST_IDLE) ? (bus.wen ? OP_WRITE : OP_READ) : op_q;
    assign cur_ok  = (64'(cur_idx) < 64'(DEPTH)) && !cur_mis;

`ifdef MISALIGN_CHECK_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = mis_q;
        if (state_q == ST_IDLE && (bus.ren || bus.wen)) begin
            mis_d = |bus.ramaddr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end

    assign cur_mis = (state_q == ST_IDLE) ? |bus.ramaddr[1:0] : mis_q;
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.ramaddr[1:0];
    assign cur_mis          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        be_d      = be_q;
        op_d      = op_q;
        ramload_d = ramload_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        to_resp   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ren || bus.wen) begin
                    idx_d  = bus.ramaddr[ADDR_W-1:2];
                    data_d = bus.ramstore;
                    be_d   = bus.byte_en;
                    op_d   = bus.wen ? OP_WRITE : OP_READ;
                    cnt_d  = CNT_INIT;
                    busy_d = 1'b1;
                    if (LATENCY == 1) to_resp = 1'b1;
                    else              state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) to_resp = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (to_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = !cur_ok;
            if (!cur_ok)                ramload_d = '0;
            else if (cur_op == OP_READ) ramload_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            be_q      <= '0;
            op_q      <= OP_READ;
            ramload_q <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            be_q      <= be_d;
            op_q      <= op_d;
            ramload_q <= ramload_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    // Writes commit at the end of the RESP cycle; a reset there aborts them.
    assign we = (state_q == ST_RESP) && (op_q == OP_WRITE) && cur_ok && !reset;

    word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_word_ram (
        .clk   (clk),
        .we    (we),
        .addr  (cur_idx[AW-1:0]),
        .wdata (data_q),
        .be    (be_q),
        .rdata (rd_data)
    );

    assign bus.ramload = ramload_q;
    assign bus.busy    = busy_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: transaction-level model checked every cycle,
// directed vectors with literal expectations, and a LATENCY=1 instance.
module tb_ram_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_responder_if #(.ADDR_W(32)) bus ();
    ram_responder_if #(.ADDR_W(32)) bus1 ();
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;

    ram_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    ram_responder #(.DEPTH(DEPTH), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .dbg_state (dbg_state1)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (LAT instance) ----------------
    // m_k counts cycles since accept; 0 means no transaction in flight.
    int          m_k     = 0;
    logic        m_write = 1'b0;
    logic        m_ok    = 1'b1;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic [3:0]  m_be    = '0;
    logic [31:0] m_load  = '0;
    logic [31:0] m_mem [DEPTH];

    function automatic bit addr_ok(input logic [31:0] a);
        bit ok;
        ok = (a >> 2) < DEPTH;
`ifdef MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) ok = 1'b0;
`endif
        return ok;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_k    = 0;
            m_load = '0;
        end else if (m_k == 0) begin
            if (bus.ren || bus.wen) begin
                m_write = bus.wen;
                m_addr  = bus.ramaddr;
                m_data  = bus.ramstore;
                m_be    = bus.byte_en;
                m_ok    = addr_ok(bus.ramaddr);
                m_k     = 1;
            end
        end else if (m_k == LAT) begin
            if (m_write && m_ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_be[i]) m_mem[int'(m_addr >> 2)][8*i +: 8] = m_data[8*i +: 8];
                end
            end
            m_k = 0;
        end else begin
            m_k++;
        end
        if (!reset && m_k == LAT) begin
            if (!m_ok)         m_load = '0;
            else if (!m_write) m_load = m_mem[int'(m_addr >> 2)];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy",    32'(bus.busy),  32'(m_k != 0));
            check("cyc_ready",   32'(bus.ready), 32'(m_k == LAT));
            check("cyc_err",     32'(bus.err),   32'(m_k == LAT && !m_ok));
            check("cyc_ramload", bus.ramload,    m_load);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge in an IDLE cycle; returns in the bubble cycle.
    task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] load, output logic e, output int cyc);
        bus.ren      = r;
        bus.wen      = w;
        bus.ramaddr  = a;
        bus.ramstore = d;
        bus.byte_en  = be;
        cyc = 1;
        @(negedge clk);
        while (!bus.ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout addr=%h no ready after %0d cycles", a, cyc);
        end
        load    = bus.ramload;
        e       = bus.err;
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic exp_err);
        logic [31:0] load;
        logic        e;
        int          cyc;
        do_req(1'b0, 1'b1, a, d, be, load, e, cyc);
        check("wr_lat", cyc, LAT);
        check("wr_err", 32'(e), 32'(exp_err));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_load, input logic exp_err);
        logic [31:0] load;
        logic        e;
        int          cyc;
        do_req(1'b1, 1'b0, a, 32'h0, 4'h0, load, e, cyc);
        check("rd_lat",  cyc, LAT);
        check("rd_load", load, exp_load);
        check("rd_err",  32'(e), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] load;
        logic        e;
        int          cyc;

        bus.ren = 1'b0;  bus.wen = 1'b0;  bus.ramaddr = '0;  bus.ramstore = '0;  bus.byte_en = '0;
        bus1.ren = 1'b0; bus1.wen = 1'b0; bus1.ramaddr = '0; bus1.ramstore = '0; bus1.byte_en = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",    32'(bus.busy),  32'd0);
        check("rst_ready",   32'(bus.ready), 32'd0);
        check("rst_err",     32'(bus.err),   32'd0);
        check("rst_ramload", bus.ramload,    32'd0);
        check("rst_state",   32'(dbg_state), 32'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // Known contents for every word read later.
        wr(32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1'b0);
        wr(32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0);
        wr(32'h0000_0030, 32'h0000_0000, 4'hF, 1'b0);

        // Write then read, with ramload held past ready.
        wr(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        repeat (2) @(negedge clk);
        check("load_held", bus.ramload, 32'hDEAD_BEEF);

        // Partial byte write.
        wr(32'h0000_0010, 32'h0000_00AA, 4'b0001, 1'b0);
        rd(32'h0000_0010, 32'hDEAD_BEAA, 1'b0);

        // Out of range read and write, word 0 untouched.
        rd(32'h0000_1000, 32'h0000_0000, 1'b1);
        wr(32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 1'b1);
        rd(32'h0000_0000, 32'h0BAD_F00D, 1'b0);

        // Last in-range word.
        wr(32'h0000_0FFC, 32'hA5A5_5A5A, 4'hF, 1'b0);
        rd(32'h0000_0FFC, 32'hA5A5_5A5A, 1'b0);

        // ren+wen together is a write.
        do_req(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, load, e, cyc);
        check("rw_err", 32'(e), 32'd0);
        rd(32'h0000_0020, 32'h1234_5678, 1'b0);

        // Zero byte enable leaves memory alone.
        wr(32'h0000_0020, 32'h0000_0000, 4'h0, 1'b0);
        rd(32'h0000_0020, 32'h1234_5678, 1'b0);

        // Reset in the WAIT cycle aborts the write.
        bus.wen = 1'b1; bus.ramaddr = 32'h0000_0030; bus.ramstore = 32'h55AA_55AA; bus.byte_en = 4'hF;
        @(negedge clk);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset   = 1'b1;
        bus.wen = 1'b0;
        @(negedge clk);
        check("abort_busy",    32'(bus.busy),  32'd0);
        check("abort_ready",   32'(bus.ready), 32'd0);
        check("abort_ramload", bus.ramload,    32'd0);
        check("abort_state",   32'(dbg_state), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_ready", 32'(bus.ready), 32'd0);
        rd(32'h0000_0030, 32'h0000_0000, 1'b0);

        // Unaligned address.
`ifdef MISALIGN_CHECK_EN
        rd(32'h0000_0011, 32'h0000_0000, 1'b1);
`else
        rd(32'h0000_0013, 32'hDEAD_BEAA, 1'b0);
`endif

        // LATENCY=1 instance: write, then hold ren to see a 2-cycle ready cadence.
        bus1.wen = 1'b1; bus1.ramaddr = 32'h0000_0010; bus1.ramstore = 32'hCAFE_F00D; bus1.byte_en = 4'hF;
        @(negedge clk);
        check("l1_wr_ready", 32'(bus1.ready), 32'd1);
        check("l1_wr_busy",  32'(bus1.busy),  32'd1);
        check("l1_wr_err",   32'(bus1.err),   32'd0);
        bus1.wen = 1'b0;
        @(negedge clk);
        check("l1_bubble_busy", 32'(bus1.busy), 32'd0);
        bus1.ren = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("l1_rd_ready", 32'(bus1.ready), 32'd1);
            check("l1_rd_busy",  32'(bus1.busy),  32'd1);
            check("l1_rd_load",  bus1.ramload,    32'hCAFE_F00D);
            @(negedge clk);
            check("l1_idle_ready", 32'(bus1.ready), 32'd0);
            check("l1_idle_busy",  32'(bus1.busy),  32'd0);
        end
        bus1.ren = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Memory-side responder for the CPU request unit. It receives the request unit's single-port RAM requests (ramaddr, ramstore, Ren, Wen), models a word-organised data/instruction RAM with configurable wait states, and returns the load data with a one-cycle ready pulse. The request unit turns this pulse into i_ready/d_ready for the pc and the datapath. The block also serves as the bench/FPGA stand-in for external memory.

Parameters:
DEPTH, 1024, number of 32-bit words stored; word index range 0..DEPTH-1
LATENCY, 2, cycles from request accept to ready pulse; legal values 1..15
ADDR_W, 32, byte-address width

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
ren  input  1  read request, level, held by the initiator until ready
wen  input  1  write request, level, held by the initiator until ready
ramaddr  input  ADDR_W  byte address; bits [1:0] ignored for word select
ramstore  input  32  write data
byte_en  input  4  per-byte write enable; bit i selects ramstore[8i+7:8i]
ramload  output  32  read data; valid in the ready cycle, held until next accept
busy  output  1  high from the accept cycle until the ready cycle, inclusive
ready  output  1  one-cycle completion pulse
err  output  1  qualifies ready; high when the access was rejected

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ramload=0; busy=0; ready=0; err=0; wait counter=0. The storage array is not cleared.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE, ren|wen=1 at an edge: capture ramaddr, ramstore, byte_en and op (write if wen, else read), load counter=LATENCY-1, busy=1. Go to RESP if LATENCY==1, otherwise go to WAIT.
- WAIT: decrement the counter each cycle. Request inputs are ignored. At counter==1, go to RESP.
- RESP (exactly one cycle): ready=1, busy=1.
  - Read: ramload=mem[index].
  - Write: bytes with byte_en set are committed at the end of this cycle; ramload is unchanged.
  - Next state is IDLE.
- Latency: for a request accepted at edge T, ready is high in the cycle after edge T+LATENCY-1. Total request-to-ready is LATENCY cycles.
- Back-to-back requests: one IDLE bubble after each ready. A request still asserted in the IDLE cycle is accepted as a new transaction, so the initiator must drop ren/wen in the ready cycle.
- ren and wen both high: treated as a write; ren is ignored.
- Word index is captured ramaddr[ADDR_W-1:2].
  - If index>=DEPTH: no write, ramload=0, err=1 with ready.
  - The out-of-range access still takes the full LATENCY.
- byte_en=0 on a write: completes normally with ready, and memory is unchanged.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted, no write commits, no ready pulse is issued, and the FSM returns to IDLE.
- Input changes while busy have no effect on the transaction in flight.

Optional Feature:
Macro: MISALIGN_CHECK_EN.
- Defined: a captured ramaddr[1:0]!=0 is flagged at accept. The access completes after LATENCY with err=1, no write, and ramload=0.
- Not defined: ramaddr[1:0] is ignored and the access proceeds to the aligned word.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t
  - typedef enum logic {OP_READ, OP_WRITE} mem_op_t
  - localparam WORD_BYTES=4
- One sub-module, word_ram:
  - DEPTH x 32 array, asynchronous read, byte-enable write on clk.
  - Instantiated once.
- FSM, counter, capture registers and range/alignment checks live in ram_responder.

Test Plan:
- Write then read: LATENCY=2; wen, ramaddr=0x10, ramstore=0xDEADBEEF, byte_en=4'hF. Expected: ready 2 cycles after accept, err=0. Then ren at 0x10: ramload=0xDEADBEEF with ready, held after ready.
- Byte enable: word 0x10=0xDEADBEEF; write 0x000000AA with byte_en=4'b0001. A read of 0x10 then returns 0xDEADBEAA.
- Out of range: DEPTH=1024; ren at 0x00001000 (index 1024). Expected: ready at LATENCY, err=1, ramload=0. A write to the same address leaves word 0 unchanged.
- Simultaneous ren+wen at 0x20 with data 0x12345678: treated as a write. A subsequent read of 0x20 returns 0x12345678.
- Reset mid-op: wen at 0x30 with data 0x55AA55AA, reset pulsed in the WAIT cycle. Expected: no ready, busy=0 and ramload=0 the cycle after reset. A read of 0x30 returns the prior contents (0x00000000 from the initial write-zero).
- LATENCY=1 with ren held continuously at 0x10: ready pulses every 2 cycles (accept, RESP, IDLE-accept...), and busy toggles accordingly. With MISALIGN_CHECK_EN defined, ren at 0x11 returns err=1.
